// File: rtl/mf_pll_supervisor.sv
// mf_pll_supervisor
// Reset and lock supervisor for the mf_pllbase clock generator. Runs on the
// always-present reference clock, pulses the PLL reset, waits for lock,
// qualifies lock for a programmable time, then releases the system reset.
// Retries a bounded number of times before latching a sticky failure.
//
// Optional feature macro: MF_PLL_SUPERVISOR_LOSS_CNT_EN
//   defined   -> 8-bit saturating count of lock losses seen in RUN
//   undefined -> loss_count is tied to zero and no register exists
//
// Handshake/timing contract: pll_locked_in is asynchronous and is only used
// after a 2-flop synchronizer (lk_q). Every output is a register that is
// updated on the same edge as state_out, so outputs and state never disagree.
module mf_pll_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES = 16,    // >= 1
    parameter int unsigned LOCK_TIMEOUT     = 74250, // >= 1
    parameter int unsigned STABLE_CYCLES    = 1024,  // >= 1
    parameter int unsigned MAX_RETRIES      = 7      // 0..15
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked_in,
    output logic       pll_rst_out,
    output logic       sys_rst_out,
    output logic [2:0] state_out,
    output logic [3:0] retry_count,
    output logic       fail,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    // The shared counter counts down to zero; a state that lasts N cycles is
    // loaded with N-1 on entry and leaves on the edge where the counter is 0.
    localparam logic [31:0] LD_RST_PULSE = 32'(RST_PULSE_CYCLES - 1);
    localparam logic [31:0] LD_TIMEOUT   = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] LD_STABLE    = 32'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        pll_rst_q, pll_rst_d;
    logic        sys_rst_q, sys_rst_d;
    logic        fail_q, fail_d;
    logic        sync1_q;
    logic        lk_q;
    logic        cnt_done;

    assign cnt_done = (cnt_q == 32'd0);

    // Two-flop synchronizer for the PLL lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            sync1_q <= pll_locked_in;
            lk_q    <= sync1_q;
        end
    end

    // State, shared counter, retry counter and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= LD_RST_PULSE;
            retry_q   <= 4'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state, counter reload/decrement and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        pll_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        fail_d    = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_done) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout
                // cycle wins over the retry.
                if (lk_q) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_done) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_RESET_PLL;
                    end
                end
            end
            ST_STABILIZE: begin
                // A dropout only restarts the lock wait; it is not a retry.
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_done) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lk_q) begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase

        // Every state entry reloads the counter; otherwise count down to 0.
        if (state_d != state_q) begin
            case (state_d)
                ST_RESET_PLL: cnt_d = LD_RST_PULSE;
                ST_WAIT_LOCK: cnt_d = LD_TIMEOUT;
                ST_STABILIZE: cnt_d = LD_STABLE;
                default:      cnt_d = 32'd0;
            endcase
        end else if (!cnt_done) begin
            cnt_d = cnt_q - 32'd1;
        end

        // Outputs follow the state being entered so they switch with it.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        sys_rst_d = (state_d != ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    assign pll_rst_out = pll_rst_q;
    assign sys_rst_out = sys_rst_q;
    assign state_out   = state_q;
    assign retry_count = retry_q;
    assign fail        = fail_q;

`ifdef MF_PLL_SUPERVISOR_LOSS_CNT_EN
    logic [7:0] loss_count_q, loss_count_d;
    logic       loss_event;

    // A lock loss is the RUN -> RESET_PLL transition.
    assign loss_event = (state_q == ST_RUN) && !lk_q;

    // Saturating increment of the loss counter.
    always_comb begin
        loss_count_d = loss_count_q;
        if (loss_event && (loss_count_q != 8'hFF)) begin
            loss_count_d = loss_count_q + 8'd1;
        end
    end

    // Loss counter register; only the external reset clears it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_count_q <= 8'd0;
        end else begin
            loss_count_q <= loss_count_d;
        end
    end

    assign loss_count = loss_count_q;
`else
    assign loss_count = 8'd0;
`endif

endmodule
